// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl
//   Multi-cycle multiply/divide unit with architectural HI/LO registers.
//   It sits in EX beside the ALU and executes the decoded mult/multu/div/divu/
//   mthi/mtlo instructions. The result is computed when the operation is
//   accepted and parked in shadow registers. A down-counter then holds `busy`
//   high for the fixed MIPS latency before HI/LO are committed. The hazard
//   unit stalls D-stage MDU instructions while (start || busy).
//
// Parameters
//   MUL_CYCLES  busy cycles for mult/multu (1..31)
//   DIV_CYCLES  busy cycles for div/divu   (1..31)
//
// Ports
//   clk      in   1   system clock, rising edge
//   reset    in   1   asynchronous active-low reset
//   start    in   1   1-cycle request; mdu_op/rs_data/rt_data valid this cycle
//   mdu_op   in   3   0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 NONE
//   rs_data  in   32  operand A / MTHI-MTLO source
//   rt_data  in   32  operand B
//   busy     out  1   operation in progress
//   done     out  1   1-cycle pulse in the first cycle the new HI/LO are visible
//   hi       out  32  architectural HI
//   lo       out  32  architectural LO
// -----------------------------------------------------------------------------
module mdu_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [4:0] MUL_CNT = 5'(MUL_CYCLES);
  localparam logic [4:0] DIV_CNT = 5'(DIV_CYCLES);

  // Full 64-bit two's-complement product.
  function automatic logic [63:0] mul_signed(input logic signed [31:0] a,
                                             input logic signed [31:0] b);
    logic signed [63:0] ax;
    logic signed [63:0] bx;
    logic signed [63:0] p;
    ax = a;
    bx = b;
    p  = ax * bx;
    return p;
  endfunction

  function automatic logic [63:0] mul_unsigned(input logic [31:0] a,
                                               input logic [31:0] b);
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Returns {remainder, quotient}. Quotient truncates toward zero and the
  // remainder takes the sign of the dividend. The single overflowing case
  // (most-negative / -1) is pinned explicitly so the result never depends on
  // how a tool treats signed overflow.
  function automatic logic [63:0] div_signed(input logic signed [31:0] a,
                                             input logic signed [31:0] b);
    logic signed [31:0] q;
    logic signed [31:0] r;
    if (a == 32'sh8000_0000 && b == -32'sd1) begin
      q = 32'sh8000_0000;
      r = 32'sd0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic logic [63:0] div_unsigned(input logic [31:0] a,
                                               input logic [31:0] b);
    return {a % b, a / b};
  endfunction

  logic [0:0]  state;
  logic [4:0]  count;
  logic [31:0] shadow_hi;
  logic [31:0] shadow_lo;
  logic        shadow_wr;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_wr;
  logic        is_mdu_op;
  logic        is_mul_op;

  // Accept stage: result computed from the operands presented with start.
  always_comb begin
    res_hi    = '0;
    res_lo    = '0;
    res_wr    = 1'b1;
    is_mdu_op = 1'b0;
    is_mul_op = 1'b0;
    case (mdu_op)
      OP_MULT: begin
        is_mdu_op        = 1'b1;
        is_mul_op        = 1'b1;
        {res_hi, res_lo} = mul_signed(rs_data, rt_data);
      end
      OP_MULTU: begin
        is_mdu_op        = 1'b1;
        is_mul_op        = 1'b1;
        {res_hi, res_lo} = mul_unsigned(rs_data, rt_data);
      end
      OP_DIV: begin
        is_mdu_op = 1'b1;
        // Divide by zero still occupies the unit but leaves HI/LO alone.
        if (rt_data == 32'd0) res_wr = 1'b0;
        else {res_hi, res_lo} = div_signed(rs_data, rt_data);
      end
      OP_DIVU: begin
        is_mdu_op = 1'b1;
        if (rt_data == 32'd0) res_wr = 1'b0;
        else {res_hi, res_lo} = div_unsigned(rs_data, rt_data);
      end
      default: ;
    endcase
  end

  // Sequencer stage: latency counter, shadow hold and HI/LO commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      shadow_hi <= '0;
      shadow_lo <= '0;
      shadow_wr <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (is_mdu_op) begin
              shadow_hi <= res_hi;
              shadow_lo <= res_lo;
              shadow_wr <= res_wr;
              count     <= is_mul_op ? MUL_CNT : DIV_CNT;
              state     <= ST_RUN;
              busy      <= 1'b1;
            end else if (mdu_op == OP_MTHI) begin
              hi <= rs_data;
            end else if (mdu_op == OP_MTLO) begin
              lo <= rs_data;
            end
          end
        end
        ST_RUN: begin
          // Requests arriving here are dropped; the hazard unit never sends any.
          count <= count - 5'd1;
          if (count == 5'd1) begin
            if (shadow_wr) begin
              hi <= shadow_hi;
              lo <= shadow_lo;
            end
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
